// File: rtl/alu_defs.sv
// Shared encodings for the ALU control path: ALUOp, funct, ALU control codes, FSM states.
package alu_defs;

  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned STATE_W = 2;

  // ALUOp encodings from the main control unit
  localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_RSV = 2'b11;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR   = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

  // ALU control codes
  localparam logic [CODE_W-1:0] CTRL_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] CTRL_OR   = 4'b0001;
  localparam logic [CODE_W-1:0] CTRL_ADD  = 4'b0010;
  localparam logic [CODE_W-1:0] CTRL_SUB  = 4'b0110;
  localparam logic [CODE_W-1:0] CTRL_SLT  = 4'b0111;
  localparam logic [CODE_W-1:0] CTRL_MFHI = 4'b1000;
  localparam logic [CODE_W-1:0] CTRL_MFLO = 4'b1001;
  localparam logic [CODE_W-1:0] CTRL_NOR  = 4'b1100;
  localparam logic [CODE_W-1:0] CTRL_INV  = 4'b1111;

  // Mult/div sequencer states
  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] ST_DONE = 2'b10;

  // True for MULT/MULTU/DIV/DIVU
  function automatic logic is_md_funct(input logic [FUNCT_W-1:0] f);
    return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALUOp/funct decode into the ALU control code.
module alu_decode
  import alu_defs::*;
#(
  parameter int unsigned CTRL_W = 4
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] alu_op,
  output logic [CTRL_W-1:0]  salida,
  output logic               ilegal,
  output logic               md_funct
);

  logic [CODE_W-1:0] code;

  // Select the control code; anything unrecognised maps to the invalid code
  always_comb begin
    code = CTRL_INV;
    case (alu_op)
      ALUOP_MEM: code = CTRL_ADD;
      ALUOP_BEQ: code = CTRL_SUB;
      ALUOP_R: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU:  code = CTRL_ADD;
          FUNCT_SUB, FUNCT_SUBU:  code = CTRL_SUB;
          FUNCT_AND:              code = CTRL_AND;
          FUNCT_OR:               code = CTRL_OR;
          FUNCT_NOR:              code = CTRL_NOR;
          FUNCT_SLT:              code = CTRL_SLT;
          FUNCT_MFHI:             code = CTRL_MFHI;
          FUNCT_MFLO:             code = CTRL_MFLO;
          FUNCT_MULT, FUNCT_MULTU,
          FUNCT_DIV, FUNCT_DIVU:  code = CTRL_ADD;  // ALU result ignored for mult/div
          default:                code = CTRL_INV;
        endcase
      end
      ALUOP_RSV: code = CTRL_INV;
      default:   code = CTRL_INV;
    endcase
  end

  assign salida   = CTRL_W'(code);
  assign ilegal   = (code == CTRL_INV);
  assign md_funct = is_md_funct(funct);

endmodule

// File: rtl/alu_control_secuencial.sv
// ALU control with an iterative mult/div sequencer (IDLE -> RUN -> DONE) and pipeline stall.
module alu_control_secuencial
  import alu_defs::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        entradaFunct,
  input  logic [1:0]        ALUOp,
  input  logic              valido,
  output logic [CTRL_W-1:0] salida,
  output logic [1:0]        md_op,
  output logic              md_paso,
  output logic              busy,
  output logic              stall,
  output logic              escribe_hilo,
  output logic              err_funct
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [STATE_W-1:0] state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         md_op_n;
  logic               err_n;
  logic               ilegal;
  logic               md_funct;
  logic               md_req;

  alu_decode #(
    .CTRL_W (CTRL_W)
  ) u_decode (
    .funct    (entradaFunct),
    .alu_op   (ALUOp),
    .salida   (salida),
    .ilegal   (ilegal),
    .md_funct (md_funct)
  );

  assign md_req = valido && (ALUOp == ALUOP_R) && md_funct;

  // Next state, counter, captured op and sticky error
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    md_op_n = md_op;
    err_n   = err_funct | (valido & ilegal);
    case (state)
      ST_IDLE: begin
        if (md_req) begin
          state_n = ST_RUN;
          cnt_n   = CNT_W'(WIDTH - 1);
          md_op_n = entradaFunct[1:0];
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      md_op     <= 2'b00;
      err_funct <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      md_op     <= md_op_n;
      err_funct <= err_n;
    end
  end

  // Status strobes decoded straight from the state register
  assign md_paso      = (state == ST_RUN);
  assign escribe_hilo = (state == ST_DONE);
  assign busy         = (state == ST_RUN) || (state == ST_DONE);
  assign stall        = ((state == ST_IDLE) && md_req) || (state == ST_RUN);

endmodule

// File: tb/tb_alu_control_secuencial.sv
// Directed bench: decode table, mult/div latency, stall, reset abort, DONE-ignore, sticky error.
module tb_alu_control_secuencial;

  logic       clk = 1'b0;
  logic       reset;

  logic [5:0] funct8, funct32;
  logic [1:0] aluop8, aluop32;
  logic       valido8, valido32;
  logic [3:0] salida8, salida32;
  logic [1:0] md_op8, md_op32;
  logic       md_paso8, md_paso32, busy8, busy32, stall8, stall32;
  logic       hilo8, hilo32, err8, err32;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_control_secuencial #(.WIDTH(8), .CTRL_W(4)) dut8 (
    .clk(clk), .reset(reset), .entradaFunct(funct8), .ALUOp(aluop8), .valido(valido8),
    .salida(salida8), .md_op(md_op8), .md_paso(md_paso8), .busy(busy8), .stall(stall8),
    .escribe_hilo(hilo8), .err_funct(err8)
  );

  alu_control_secuencial #(.WIDTH(32), .CTRL_W(4)) dut32 (
    .clk(clk), .reset(reset), .entradaFunct(funct32), .ALUOp(aluop32), .valido(valido32),
    .salida(salida32), .md_op(md_op32), .md_paso(md_paso32), .busy(busy32), .stall(stall32),
    .escribe_hilo(hilo32), .err_funct(err32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are changed 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [1:0] op, input logic [5:0] f, input logic v);
    aluop8 = op; funct8 = f; valido8 = v;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive8(2'b00, 6'd0, 1'b0);
    aluop32 = 2'b00; funct32 = 6'd0; valido32 = 1'b0;
    step(); step();
    // Reset state
    chk("rst_busy",  32'(busy8), 32'd0);
    chk("rst_paso",  32'(md_paso8), 32'd0);
    chk("rst_hilo",  32'(hilo8), 32'd0);
    chk("rst_err",   32'(err8), 32'd0);
    chk("rst_md_op", 32'(md_op8), 32'd0);
    chk("rst_stall", 32'(stall8), 32'd0);
    reset = 1'b0;

    // Decode table
    drive8(2'b10, 6'b100111, 1'b1);
    chk("nor_salida", 32'(salida8), 32'hC);
    chk("nor_stall",  32'(stall8), 32'd0);
    step();
    chk("nor_err", 32'(err8), 32'd0);
    drive8(2'b00, 6'b111111, 1'b1); chk("lw_salida",   32'(salida8), 32'h2);
    drive8(2'b01, 6'b111111, 1'b1); chk("beq_salida",  32'(salida8), 32'h6);
    drive8(2'b10, 6'b101010, 1'b1); chk("slt_salida",  32'(salida8), 32'h7);
    drive8(2'b10, 6'b100001, 1'b1); chk("addu_salida", 32'(salida8), 32'h2);
    drive8(2'b10, 6'b100011, 1'b1); chk("subu_salida", 32'(salida8), 32'h6);
    drive8(2'b10, 6'b100100, 1'b1); chk("and_salida",  32'(salida8), 32'h0);
    drive8(2'b10, 6'b100101, 1'b1); chk("or_salida",   32'(salida8), 32'h1);
    drive8(2'b10, 6'b010000, 1'b1); chk("mfhi_salida", 32'(salida8), 32'h8);
    step();
    chk("legal_err", 32'(err8), 32'd0);

    // Illegal encodings with valido=0 leave err_funct clear
    drive8(2'b11, 6'b100000, 1'b0);
    chk("rsv_salida", 32'(salida8), 32'hF);
    step();
    chk("rsv_novalid_err", 32'(err8), 32'd0);
    drive8(2'b10, 6'b111111, 1'b0);
    step();
    chk("bad_novalid_err", 32'(err8), 32'd0);

    // Illegal funct with valido=1 sets sticky error
    drive8(2'b10, 6'b111111, 1'b1);
    chk("bad_salida", 32'(salida8), 32'hF);
    step();
    chk("bad_err_set", 32'(err8), 32'd1);
    drive8(2'b10, 6'b111111, 1'b0);
    step();
    chk("bad_err_hold", 32'(err8), 32'd1);
    drive8(2'b10, 6'b100000, 1'b1);
    step(); step();
    chk("bad_err_sticky", 32'(err8), 32'd1);
    reset = 1'b1;
    step();
    chk("err_cleared", 32'(err8), 32'd0);
    reset = 1'b0;

    // DIVU then MFLO held stalled until DONE (WIDTH=8)
    drive8(2'b10, 6'b011011, 1'b1);
    chk("divu_req_stall", 32'(stall8), 32'd1);
    chk("divu_req_busy",  32'(busy8), 32'd0);
    chk("divu_req_paso",  32'(md_paso8), 32'd0);
    step();
    drive8(2'b10, 6'b010010, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("divu_run_paso",  32'(md_paso8), 32'd1);
      chk("divu_run_stall", 32'(stall8), 32'd1);
      chk("divu_run_md_op", 32'(md_op8), 32'd3);
      chk("divu_run_hilo",  32'(hilo8), 32'd0);
      chk("divu_run_busy",  32'(busy8), 32'd1);
      step();
    end
    chk("divu_done_hilo",   32'(hilo8), 32'd1);
    chk("divu_done_stall",  32'(stall8), 32'd0);
    chk("divu_done_busy",   32'(busy8), 32'd1);
    chk("divu_done_paso",   32'(md_paso8), 32'd0);
    chk("divu_done_md_op",  32'(md_op8), 32'd3);
    chk("mflo_salida",      32'(salida8), 32'h9);
    step();
    chk("divu_idle_busy", 32'(busy8), 32'd0);
    chk("divu_idle_hilo", 32'(hilo8), 32'd0);
    chk("mflo_nostall",   32'(stall8), 32'd0);

    // MULTU aborted by reset in the third RUN cycle
    drive8(2'b10, 6'b011001, 1'b1);
    step(); step(); step();
    chk("abort_pre_busy", 32'(busy8), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_busy",  32'(busy8), 32'd0);
    chk("abort_hilo",  32'(hilo8), 32'd0);
    chk("abort_paso",  32'(md_paso8), 32'd0);
    chk("abort_md_op", 32'(md_op8), 32'd0);
    // Reset wins over a simultaneous request
    step();
    chk("rst_prio_busy", 32'(busy8), 32'd0);
    reset = 1'b0;
    #1;
    chk("multu_req_stall", 32'(stall8), 32'd1);
    step();
    chk("multu_run_busy",  32'(busy8), 32'd1);
    chk("multu_run_md_op", 32'(md_op8), 32'd1);
    chk("multu_run_paso",  32'(md_paso8), 32'd1);
    for (int i = 0; i < 8; i++) step();
    // Request still presented while in DONE: ignored, then accepted from IDLE
    chk("multu_done_hilo",  32'(hilo8), 32'd1);
    chk("multu_done_stall", 32'(stall8), 32'd0);
    step();
    chk("redo_idle_busy",  32'(busy8), 32'd0);
    chk("redo_idle_hilo",  32'(hilo8), 32'd0);
    chk("redo_idle_stall", 32'(stall8), 32'd1);
    step();
    chk("redo_run_busy", 32'(busy8), 32'd1);
    chk("redo_run_paso", 32'(md_paso8), 32'd1);
    drive8(2'b10, 6'b100000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("redo_run_hilo", 32'(hilo8), 32'd0);
      step();
    end
    chk("redo_last_paso", 32'(md_paso8), 32'd1);
    step();
    chk("redo_done_hilo", 32'(hilo8), 32'd1);
    step();
    chk("redo_end_busy", 32'(busy8), 32'd0);

    // MULT on the WIDTH=32 instance: 32 md_paso pulses then one write strobe
    aluop32 = 2'b10; funct32 = 6'b011000; valido32 = 1'b1;
    #1;
    chk("mult32_req_stall", 32'(stall32), 32'd1);
    step();
    for (int i = 0; i < 32; i++) begin
      chk("mult32_run_paso",  32'(md_paso32), 32'd1);
      chk("mult32_run_hilo",  32'(hilo32), 32'd0);
      chk("mult32_run_stall", 32'(stall32), 32'd1);
      step();
    end
    chk("mult32_done_hilo",  32'(hilo32), 32'd1);
    chk("mult32_done_stall", 32'(stall32), 32'd0);
    chk("mult32_done_paso",  32'(md_paso32), 32'd0);
    chk("mult32_md_op",      32'(md_op32), 32'd0);
    valido32 = 1'b0;
    step();
    chk("mult32_end_busy", 32'(busy32), 32'd0);
    chk("mult32_end_hilo", 32'(hilo32), 32'd0);
    chk("mult32_err",      32'(err32), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
